// File: rtl/ping_pong_buffer_pkg.sv
`default_nettype none
// ============================================================================
// ping_pong_buffer_pkg : word width and bank geometry shared with the output mux
// Revision: 1.0
// ============================================================================
package ping_pong_buffer_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int DEPTH      = 8;
   localparam int ADDR_WIDTH = $clog2(DEPTH);

   typedef logic [DATA_WIDTH-1:0] word_t;

endpackage
`default_nettype wire

// File: rtl/ping_pong_buffer_reg_bank.sv
`default_nettype none
// ============================================================================
// ping_pong_buffer_reg_bank : DEPTH x DATA_WIDTH register file, 1 sync write, 1 async read
// Revision: 1.0
// ============================================================================
module ping_pong_buffer_reg_bank
   import ping_pong_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = ping_pong_buffer_pkg::DATA_WIDTH,
   parameter int DEPTH      = ping_pong_buffer_pkg::DEPTH,
   parameter int ADDR_WIDTH = ping_pong_buffer_pkg::ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/ping_pong_buffer.sv
`default_nettype none
// ============================================================================
// ping_pong_buffer : two-bank double buffer feeding the A/B/S inputs of the output mux
// Revision: 1.0
// ============================================================================
module ping_pong_buffer
   import ping_pong_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = ping_pong_buffer_pkg::DATA_WIDTH,
   parameter int DEPTH      = ping_pong_buffer_pkg::DEPTH,
   parameter int ADDR_WIDTH = ping_pong_buffer_pkg::ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ready,
   input  logic                  rd_en,
   output logic                  rd_valid,
   output logic                  rd_last,
   output logic [DATA_WIDTH-1:0] A,
   output logic [DATA_WIDTH-1:0] B,
   output logic                  S
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   logic                  wr_sel_q,  wr_sel_d;
   logic                  rd_sel_q,  rd_sel_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [1:0]            full_q,    full_d;

   logic                  wr_acc;
   logic                  rd_acc;
   logic                  bank_we;
   logic [DATA_WIDTH-1:0] bank_rdata [2];

   assign wr_ready = ~full_q[wr_sel_q];
   assign rd_valid = full_q[rd_sel_q];
   assign rd_last  = rd_valid & (rd_addr_q == LAST_ADDR);
   assign S        = rd_sel_q;
   assign A        = bank_rdata[0];
   assign B        = bank_rdata[1];

   assign wr_acc  = wr_en & wr_ready;
   assign rd_acc  = rd_en & rd_valid;
   // A flush in the same cycle must not leave a stray word behind the reset pointer.
   assign bank_we = wr_acc & ~flush;

   // Writer only targets a non-full bank and reader only a full one, so the two
   // full-bit updates below never hit the same bank in one cycle.
   always_comb begin
      wr_sel_d  = wr_sel_q;
      rd_sel_d  = rd_sel_q;
      wr_addr_d = wr_addr_q;
      rd_addr_d = rd_addr_q;
      full_d    = full_q;

      if (wr_acc) begin
         wr_addr_d = wr_addr_q + ADDR_ONE;
         if (wr_addr_q == LAST_ADDR) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
         end
      end

      if (rd_acc) begin
         rd_addr_d = rd_addr_q + ADDR_ONE;
         if (rd_last) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
         end
      end

      if (flush) begin
         wr_sel_d  = 1'b0;
         rd_sel_d  = 1'b0;
         wr_addr_d = '0;
         rd_addr_d = '0;
         full_d    = 2'b00;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_sel_q  <= 1'b0;
         rd_sel_q  <= 1'b0;
         wr_addr_q <= '0;
         rd_addr_q <= '0;
         full_q    <= 2'b00;
      end else begin
         wr_sel_q  <= wr_sel_d;
         rd_sel_q  <= rd_sel_d;
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
         full_q    <= full_d;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      localparam logic BANK_ID = 1'(b);

      ping_pong_buffer_reg_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_bank (
         .clk   (clk),
         .rst   (rst),
         .we    (bank_we & (wr_sel_q == BANK_ID)),
         .waddr (wr_addr_q),
         .wdata (wr_data),
         .raddr (rd_addr_q),
         .rdata (bank_rdata[b])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_ping_pong_buffer.sv
`default_nettype none
// ============================================================================
// tb_ping_pong_buffer : directed self-checking bench for ping_pong_buffer
// Revision: 1.0
// ============================================================================
module tb_ping_pong_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        rd_en;
   logic        rd_valid;
   logic        rd_last;
   logic [31:0] A;
   logic [31:0] B;
   logic        S;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ping_pong_buffer dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .rd_en    (rd_en),
      .rd_valid (rd_valid),
      .rd_last  (rd_last),
      .A        (A),
      .B        (B),
      .S        (S)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst     = 1'b1;
      flush   = 1'b0;
      wr_en   = 1'b1;
      wr_data = 32'hFFFF_FFFF;
      rd_en   = 1'b0;
      cyc();
      cyc();
      rst   = 1'b0;
      wr_en = 1'b0;

      // Reset state; the writes held during reset must not land.
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_last",  32'(rd_last),  32'd0);
      chk("rst_S",        32'(S),        32'd0);
      chk("rst_A",        A,             32'h0);
      chk("rst_B",        B,             32'h0);

      // Fill bank 0 with 1..8.
      for (int i = 0; i < 8; i++) begin
         wr_en   = 1'b1;
         wr_data = 32'(i + 1);
         chk("fill0_wr_ready", 32'(wr_ready), 32'd1);
         if (i == 7) chk("fill0_rd_valid_before_last", 32'(rd_valid), 32'd0);
         cyc();
      end
      wr_en = 1'b0;
      chk("fill0_rd_valid", 32'(rd_valid), 32'd1);
      chk("fill0_S",        32'(S),        32'd0);
      chk("fill0_A",        A,             32'h1);
      chk("fill0_rd_last",  32'(rd_last),  32'd0);
      chk("fill0_wr_ready", 32'(wr_ready), 32'd1);

      // Drain bank 0 while filling bank 1; both complete on the same edge.
      for (int i = 0; i < 8; i++) begin
         rd_en   = 1'b1;
         wr_en   = 1'b1;
         wr_data = 32'h11 + 32'(i);
         chk("drain0_A",        A,             32'(i + 1));
         chk("drain0_rd_last",  32'(rd_last),  (i == 7) ? 32'd1 : 32'd0);
         chk("drain0_rd_valid", 32'(rd_valid), 32'd1);
         chk("drain0_wr_ready", 32'(wr_ready), 32'd1);
         cyc();
      end
      rd_en = 1'b0;
      wr_en = 1'b0;
      chk("simul_S",        32'(S),        32'd1);
      chk("simul_B",        B,             32'h11);
      chk("simul_rd_valid", 32'(rd_valid), 32'd1);
      chk("simul_wr_ready", 32'(wr_ready), 32'd1);

      // Flush to a clean start, then fill both banks without reading.
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("flush1_rd_valid", 32'(rd_valid), 32'd0);
      chk("flush1_S",        32'(S),        32'd0);
      chk("flush1_wr_ready", 32'(wr_ready), 32'd1);

      for (int i = 0; i < 16; i++) begin
         wr_en   = 1'b1;
         wr_data = 32'h21 + 32'(i);
         chk("bp_fill_wr_ready", 32'(wr_ready), 32'd1);
         cyc();
      end
      chk("bp_full_wr_ready", 32'(wr_ready), 32'd0);
      chk("bp_full_rd_valid", 32'(rd_valid), 32'd1);
      chk("bp_full_A",        A,             32'h21);
      chk("bp_full_B",        B,             32'h29);

      wr_data = 32'hDEAD_BEEF;
      cyc();
      wr_en = 1'b0;
      chk("bp_drop_wr_ready", 32'(wr_ready), 32'd0);
      chk("bp_drop_A",        A,             32'h21);
      chk("bp_drop_B",        B,             32'h29);

      for (int i = 0; i < 8; i++) begin
         rd_en = 1'b1;
         chk("bp_drain_A",        A,             32'h21 + 32'(i));
         chk("bp_drain_wr_ready", 32'(wr_ready), 32'd0);
         cyc();
      end
      rd_en = 1'b0;
      chk("bp_free_wr_ready", 32'(wr_ready), 32'd1);
      chk("bp_free_S",        32'(S),        32'd1);
      chk("bp_free_rd_valid", 32'(rd_valid), 32'd1);
      chk("bp_free_B",        B,             32'h29);
      chk("bp_old_A",         A,             32'h21);

      rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
      chk("bp_rd1_A", A, 32'h22);
      chk("bp_rd1_B", B, 32'h2A);

      // Partially refill bank 0, then flush together with a write.
      for (int i = 0; i < 5; i++) begin
         wr_en   = 1'b1;
         wr_data = 32'h41 + 32'(i);
         cyc();
      end
      chk("part_A", A, 32'h42);
      wr_data = 32'h99;
      flush   = 1'b1;
      cyc();
      flush = 1'b0;
      wr_en = 1'b0;
      chk("flush2_rd_valid", 32'(rd_valid), 32'd0);
      chk("flush2_S",        32'(S),        32'd0);
      chk("flush2_wr_ready", 32'(wr_ready), 32'd1);
      chk("flush2_rd_last",  32'(rd_last),  32'd0);
      chk("flush2_A",        A,             32'h41);

      for (int i = 0; i < 8; i++) begin
         wr_en   = 1'b1;
         wr_data = 32'h51 + 32'(i);
         cyc();
      end
      wr_en = 1'b0;
      chk("refill_rd_valid", 32'(rd_valid), 32'd1);
      chk("refill_S",        32'(S),        32'd0);
      for (int i = 0; i < 8; i++) begin
         rd_en = 1'b1;
         chk("refill_A",       A,            32'h51 + 32'(i));
         chk("refill_rd_last", 32'(rd_last), (i == 7) ? 32'd1 : 32'd0);
         cyc();
      end

      // Bank 1 is empty now: reads must be ignored.
      chk("empty_rd_valid", 32'(rd_valid), 32'd0);
      chk("empty_S",        32'(S),        32'd1);
      cyc();
      rd_en = 1'b0;
      chk("ignored_rd_S",  32'(S), 32'd1);
      chk("ignored_rd_B",  B,      32'h29);
      chk("ignored_rd_wr_ready", 32'(wr_ready), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/ping_pong_buffer.md
Name: ping_pong_buffer

Overview:
- Double-buffered word store that sits directly upstream of the 32-bit 2:1 output mux in the DCNN datapath.
- A producer (e.g. the convolution/accumulate stage) fills one bank of DEPTH words while the consumer drains the other.
- The block drives the mux's A input from bank 0, its B input from bank 1, and the select S to pick the bank currently being read.
- The downstream mux output Dout therefore carries the read word.

Parameters:
- DATA_WIDTH, 32, width of each stored word and of A/B.
- DEPTH, 8, words per bank (power of two, >= 2).
- ADDR_WIDTH, 3, log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of both banks' status and all pointers; storage contents untouched.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  word to store.
- wr_ready  out  1  write bank can accept a word.
- rd_en  in  1  consumer takes the current word.
- rd_valid  out  1  read bank full; A/B/S present a valid word.
- rd_last  out  1  current word is the last of the read bank.
- A  out  DATA_WIDTH  bank 0 word at rd_addr (to mux A).
- B  out  DATA_WIDTH  bank 1 word at rd_addr (to mux B).
- S  out  1  read-bank select (0 = bank 0/A, 1 = bank 1/B).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; all state changes on the rising edge of clk.
- Reset (rst=1 at an edge), takes priority over everything:
  - wr_sel=0, rd_sel=0, wr_addr=0, rd_addr=0, full[1:0]=00, all storage cleared to 0.
  - Output values after reset: wr_ready=1, rd_valid=0, rd_last=0, A=0, B=0, S=0.
- flush=1 (with rst=0): same as reset, except storage is not cleared. Flush beats wr_en and rd_en in the same cycle.
- Write side:
  - A write is accepted when wr_en & wr_ready.
  - wr_ready = !full[wr_sel] (combinational from registers).
  - An accepted write stores wr_data at bank[wr_sel][wr_addr] and increments wr_addr.
  - When the accepted write has wr_addr=DEPTH-1: set full[wr_sel]=1, wr_addr wraps to 0, wr_sel toggles.
  - wr_en while wr_ready=0 is ignored: no store, no pointer change.
- Read side:
  - rd_valid = full[rd_sel].
  - A = bank0[rd_addr], B = bank1[rd_addr] (asynchronous read, 0-cycle).
  - S = rd_sel.
  - rd_last = rd_valid & (rd_addr=DEPTH-1).
  - A read is accepted when rd_en & rd_valid; rd_addr increments.
  - On an accepted read with rd_last=1: clear full[rd_sel], rd_addr wraps to 0, rd_sel toggles.
  - rd_en while rd_valid=0 is ignored.
- Latency:
  - rd_valid rises the cycle after the DEPTH-th write to a bank.
  - A freed bank makes wr_ready rise the cycle after the last read of that bank, when it is the write target.
- Simultaneous events:
  - Write completing one bank and read completing the other bank in the same cycle: both updates apply; the full bits are computed per-bank, with no lost update.
  - wr_sel and rd_sel never reference the same bank while it is being both filled and drained. The invariant is: rd_sel == wr_sel implies that bank is either empty (being filled) or full (being drained, writes stalled).
  - Both banks full: wr_ready=0 until the read bank drains.
- Steady state: with continuous wr_en and rd_en, throughput is 1 word/cycle on each side after the first bank fills.
- Arithmetic: pointers are ADDR_WIDTH-bit, modulo-DEPTH wrap, with no saturation.

Decomposition:
- Shared package:
  - DATA_WIDTH constant (32), shared with the mux.
  - word subtype std_logic_vector(DATA_WIDTH-1 downto 0).
  - DEPTH/ADDR_WIDTH defaults.
- Sub-module reg_bank:
  - DEPTH x DATA_WIDTH register file.
  - One synchronous write port (we, waddr, wdata), one asynchronous read port (raddr, rdata), synchronous clear on rst.
  - Instantiated twice (bank 0, bank 1). Top level holds pointers, full bits and the handshake logic.

Test Plan:
- Reset: assert rst for 2 cycles with wr_en=1, wr_data=0xFFFFFFFF -> wr_ready=1, rd_valid=0, S=0, A=B=0x00000000; nothing stored.
- Fill bank 0:
  - Stimulus: write 0x00000001..0x00000008 on consecutive cycles with rd_en=0.
  - Required response: rd_valid=1 the next cycle, S=0, A=0x00000001, rd_last=0, wr_ready=1 (writing bank 1).
- Drain with concurrent fill:
  - Stimulus: hold rd_en=1 for 8 cycles while writing 0x00000011..0x00000018.
  - Required response: A sequences 0x01..0x08, rd_last only on 0x08; next cycle S=1, B=0x00000011, rd_valid=1.
- Back-pressure:
  - Stimulus: fill both banks (16 writes) with rd_en=0.
  - Required response: wr_ready=0; a 17th wr_en with 0xDEADBEEF is dropped.
  - Stimulus: then 8 reads.
  - Required response: wr_ready=1 the cycle after the 8th read, and bank 0 still holds its old data until rewritten.
- Simultaneous complete: the 8th write of bank 1 and the last read of bank 0 occur in the same cycle -> next cycle full=10, rd_sel=1, wr_sel=0, rd_valid=1, wr_ready=1.
- Flush mid-operation:
  - Stimulus: after 5 writes to bank 0, assert flush together with wr_en.
  - Required response: wr_addr=0, full=00, rd_valid=0, S=0; the next 8 writes refill bank 0 starting at address 0.
